// File: rtl/komandara_k10_pkg.sv
// komandara_k10_pkg: shared constants and types for the K10 register file
package komandara_k10_pkg;
    localparam int RF_DATA_W_DEFAULT   = 32;
    localparam int RF_NUM_REGS_DEFAULT = 32;
    typedef logic [$clog2(RF_NUM_REGS_DEFAULT)-1:0] rf_addr_t;
endpackage

// File: rtl/k10_rf_scoreboard.sv
// k10_rf_scoreboard: per-register busy bits with flush > alloc > writeback-clear priority
import komandara_k10_pkg::*;
module k10_rf_scoreboard #(
    parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    input  logic                     i_flush,
    output logic [NUM_REGS-1:0]      o_busy_vec
);
    logic [NUM_REGS-1:0] set_v, clr_v;
    // out-of-range addresses never match an index below NUM_REGS, so they fall out naturally
    always_comb begin
        set_v = '0;
        clr_v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            set_v[i] = i_alloc_en && i_alloc_addr == ADDR_W'(i) && !(ZERO_REG != 0 && i == 0);
            for (int k = 0; k < NUM_WR; k++)
                clr_v[i] = clr_v[i] | (i_wr_en[k] && i_wr_addr[k*ADDR_W +: ADDR_W] == ADDR_W'(i));
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) o_busy_vec <= '0;
        else          o_busy_vec <= i_flush ? '0 : (o_busy_vec & ~clr_v) | set_v;
endmodule

// File: rtl/k10_regfile_mp.sv
// k10_regfile_mp: multi-port register file with write-pending scoreboard
// Define K10_RF_WRITE_THROUGH_EN to bypass same-cycle write data and busy onto the read ports.
import komandara_k10_pkg::*;
module k10_regfile_mp #(
    parameter int DATA_W   = RF_DATA_W_DEFAULT,
    parameter int NUM_REGS = RF_NUM_REGS_DEFAULT,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] o_rd_data,
    output logic [NUM_RD-1:0]        o_rd_busy,
    input  logic [NUM_WR-1:0]        i_wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] i_wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] i_wr_data,
    input  logic                     i_alloc_en,
    input  logic [ADDR_W-1:0]        i_alloc_addr,
    input  logic                     i_flush,
    output logic [NUM_REGS-1:0]      o_busy_vec
);
    logic [DATA_W-1:0] mem [NUM_REGS];
    logic [ADDR_W-1:0] wa [NUM_WR];
    logic [DATA_W-1:0] wd [NUM_WR];
    logic [NUM_WR-1:0] wr_ok;
    logic [ADDR_W-1:0] ra;
    logic              r_ok;

    k10_rf_scoreboard #(
        .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .NUM_WR(NUM_WR), .ZERO_REG(ZERO_REG)
    ) u_sb (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
        .i_alloc_en(i_alloc_en), .i_alloc_addr(i_alloc_addr), .i_flush(i_flush),
        .o_busy_vec(o_busy_vec)
    );

    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa[k]    = i_wr_addr[k*ADDR_W +: ADDR_W];
            wd[k]    = i_wr_data[k*DATA_W +: DATA_W];
            wr_ok[k] = i_wr_en[k] && int'(wa[k]) < NUM_REGS && !(ZERO_REG != 0 && wa[k] == '0);
        end
    end

    // ascending port order lets the highest-index port win a same-address collision
    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++)
                if (wr_ok[k]) mem[wa[k]] <= wd[k];
        end

    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        ra        = '0;
        r_ok      = 1'b0;
        for (int p = 0; p < NUM_RD; p++) begin
            ra   = i_rd_addr[p*ADDR_W +: ADDR_W];
            r_ok = int'(ra) < NUM_REGS && !(ZERO_REG != 0 && ra == '0);
            o_rd_data[p*DATA_W +: DATA_W] = r_ok ? mem[ra] : '0;
            o_rd_busy[p] = r_ok && o_busy_vec[ra];
`ifdef K10_RF_WRITE_THROUGH_EN
            // a same-cycle alloc to the bypassed register means a newer producer is pending
            for (int k = 0; k < NUM_WR; k++)
                if (wr_ok[k] && wa[k] == ra) begin
                    o_rd_data[p*DATA_W +: DATA_W] = wd[k];
                    o_rd_busy[p] = i_alloc_en && i_alloc_addr == ra;
                end
`endif
        end
    end
endmodule

// File: doc/k10_regfile_mp.md
# k10_regfile_mp

Parametrised multi-port integer register file with an integrated write-pending scoreboard, for dual-issue and wider K10 derivatives. Provides NUM_RD combinational read ports and NUM_WR synchronous write ports. Each register carries a busy bit: set when a producer is allocated at issue, cleared when that producer writes back. Issue logic uses the busy bits for RAW hazard stalls. It sits between decode/issue (read and allocate) and writeback (write and clear).

## Interface
- DATA_W, 32: register width in bits
- NUM_REGS, 32: number of architectural registers (2..64); ADDR_W = $clog2(NUM_REGS)
- NUM_RD, 2: read ports (1..6)
- NUM_WR, 1: write ports (1..3)
- ZERO_REG, 1: 1 = register 0 hardwired to zero, never busy

- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_rd_addr  in  NUM_RD×ADDR_W  read addresses
- o_rd_data  out  NUM_RD×DATA_W  read data
- o_rd_busy  out  NUM_RD  busy bit of addressed register
- i_wr_en  in  NUM_WR  write enables
- i_wr_addr  in  NUM_WR×ADDR_W  write addresses
- i_wr_data  in  NUM_WR×DATA_W  write data
- i_alloc_en  in  1  mark one register busy (issue of a producer)
- i_alloc_addr  in  ADDR_W  register to mark busy
- i_flush  in  1  clear all busy bits (pipeline flush); data untouched
- o_busy_vec  out  NUM_REGS  registered busy bits, bit i = register i

## Operation
- Reset: all registers 0; all busy bits 0; o_busy_vec = 0; every o_rd_data = 0; every o_rd_busy = 0.
- Write: on a clock edge with i_wr_en[k], register i_wr_addr[k] takes i_wr_data[k], and its busy bit clears.
- Write-write collision: when several ports write the same address in one cycle, the highest-index port wins for data.
- Alloc: on a clock edge with i_alloc_en, the busy bit of i_alloc_addr sets.
- Alloc vs. write, same address, same cycle: alloc wins and busy stays 1 (a newer producer exists). Write data is still stored.
- i_flush: clears every busy bit at the edge. It overrides a same-cycle alloc, which is dropped. Writes in that cycle still update data.
- ZERO_REG=1, address 0:
  - Reads return 0 and o_rd_busy = 0.
  - Writes are ignored.
  - Allocs are ignored.
- Out-of-range address (≥ NUM_REGS, when NUM_REGS is not a power of two):
  - Reads return 0, not busy.
  - Writes and allocs are ignored.
- Reads: purely combinational from the address. o_rd_busy is the stored busy bit, subject to forwarding (see Configuration).

## Timing
- Read latency: 0 cycles (combinational).
- Stored data: visible one cycle after the write edge.
- Busy set/clear: visible on o_busy_vec one cycle after the edge.
- No handshake; all inputs are sampled every edge.
- Reset asserted mid-operation: immediate asynchronous return to the reset state. The first edge after deassertion behaves as a normal cycle.

## Configuration
- K10_RF_WRITE_THROUGH_EN defined:
  - A read whose address matches an enabled same-cycle write returns that write's data, highest-index matching port.
  - o_rd_busy for that port is forced 0, unless i_alloc_en targets the same address that cycle.
- Undefined:
  - Reads return stored data and the stored busy bit only.
  - Same-cycle write data appears the following cycle.

## Structure
- komandara_k10_pkg holds:
  - RF_DATA_W_DEFAULT and RF_NUM_REGS_DEFAULT constants
  - rf_addr_t typedef for the 32-register default
- Sub-module k10_rf_scoreboard: busy-bit vector with alloc/clear/flush priority logic and o_busy_vec.
- Data array, read muxes and bypass stay in k10_regfile_mp.

## Test plan
- Reset, then read all addresses on both ports → data 0, busy 0. Write 0xDEADBEEF to r5, read next cycle → 0xDEADBEEF.
- NUM_WR=2: port0 writes r7=0x11, port1 writes r7=0x22 in the same cycle → r7 reads 0x22.
- Alloc r3; two cycles later write r3=0x55 → o_rd_busy 1 until the write edge, then 0. Alloc and write r3 in the same cycle → busy remains 1.
- Write 0xFFFF_FFFF to r0 and alloc r0 (ZERO_REG=1) → reads 0, busy 0.
- Alloc r1, r2; assert i_flush together with alloc r4 → o_busy_vec = 0 next cycle.
- Write-through: write r9=0xA5A5 while reading r9 → with macro, same-cycle read 0xA5A5 and busy 0; without macro, old value, 0xA5A5 next cycle.
